sync_fifo_flags: RTL and testbench

Single-clock, parametrised FIFO with an occupancy counter, programmable almost-full/almost-empty thresholds and sticky-free overflow/underflow error pulses. It is the same-clock-domain counterpart of the dual-clock FIFO, used wherever producer and consumer share one clock and gray-code synchronisers are unnecessary. Its finer status outputs drive back-pressure ahead of the hard full/empty limits.

---
 rtl/sync_fifo_flags.sv | 119 +++++++++++
 tb/tb_sync_fifo_flags.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds
// and one-cycle overflow/underflow pulses. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_flags #(
    parameter int DATA_WIDTH    = 16,
    parameter int FIFO_DEPTH    = 8,
    parameter int ADDR_WIDTH    = 3,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0]   AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0]   AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  full_c, empty_c;
    logic                  wr_acc, rd_acc;

    // Status flags decode only the registered count, so they never glitch on request inputs.
    always_comb begin
        full_c       = (count_q == DEPTH_C);
        empty_c      = (count_q == '0);
        almost_full  = (count_q >= AFULL_C);
        almost_empty = (count_q <= AEMPTY_C);
        full         = full_c;
        empty        = empty_c;
        count        = count_q;
        overflow     = overflow_q;
        underflow    = underflow_q;
    end

    always_comb begin
        wr_acc      = wr_en && !full_c;
        rd_acc      = rd_en && !empty_c;
        overflow_d  = wr_en && full_c;
        underflow_d = rd_en && empty_c;
        wr_ptr_d    = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d    = rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; reset only discards it logically via the pointers.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    always_comb begin
        rd_data  = mem_q[rd_ptr_q];
        rd_valid = !empty_c;
    end
`else
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    always_comb begin
        rd_data_d  = rd_acc ? mem_q[rd_ptr_q] : rd_data_q;
        rd_valid_d = rd_acc;
        rd_data    = rd_data_q;
        rd_valid   = rd_valid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags: vector table plus data scoreboard and corner sequences.
module tb_sync_fifo_flags;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [3:0]    count;
    logic          overflow;
    logic          underflow;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] sb_q[$];

    typedef struct {
        logic          wr;
        logic          rd;
        logic [DW-1:0] data;
        int            cnt;
        logic          f;
        logic          e;
        logic          af;
        logic          ae;
        logic          ov;
        logic          un;
    } vec_t;

    vec_t vecs[20];

    sync_fifo_flags #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(3),
        .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // One clock of stimulus; expectations come from the scoreboard occupancy before the edge.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
        int  sz;
        logic rd_acc, wr_acc;
        logic [DW-1:0] exp_d;
        sz     = sb_q.size();
        rd_acc = r && (sz != 0);
        wr_acc = w && (sz != DEPTH);
        wr_en = w; rd_en = r; wr_data = d;
`ifdef SYNC_FIFO_FWFT_EN
        #1;
        chk("fwft_rd_valid", int'(rd_valid), int'(sz != 0));
        if (rd_acc) chk("fwft_rd_data", int'(rd_data), int'(sb_q[0]));
`endif
        @(posedge clk);
        #1;
        if (rd_acc) exp_d = sb_q.pop_front();
        else        exp_d = '0;
        if (wr_acc) sb_q.push_back(d);
`ifndef SYNC_FIFO_FWFT_EN
        chk("rd_valid", int'(rd_valid), int'(rd_acc));
        if (rd_acc) chk("rd_data", int'(rd_data), int'(exp_d));
`endif
        chk("overflow", int'(overflow), int'(w && sz == DEPTH));
        chk("underflow", int'(underflow), int'(r && sz == 0));
        sz = sb_q.size();
        chk("count", int'(count), sz);
        chk("full", int'(full), int'(sz == DEPTH));
        chk("empty", int'(empty), int'(sz == 0));
        chk("almost_full", int'(almost_full), int'(sz >= AF));
        chk("almost_empty", int'(almost_empty), int'(sz <= AE));
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        // wr rd data cnt full empty af ae ov un
        for (int i = 0; i < 8; i++)
            vecs[i] = '{1'b1, 1'b0, DW'(i + 1), i + 1, (i == 7), 1'b0, (i >= 5), (i <= 1), 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 16'hDEAD, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 16'hBEEF, 7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 11; i < 18; i++)
            vecs[i] = '{1'b0, 1'b1, 16'h0000, 17 - i, 1'b0, (i == 17), (i <= 11), (i >= 15), 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 16'h0000, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[19] = '{1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_almost_empty", int'(almost_empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_almost_full", int'(almost_full), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_underflow", int'(underflow), 0);
`ifndef SYNC_FIFO_FWFT_EN
        chk("rst_rd_data", int'(rd_data), 0);
`endif
        chk("rst_rd_valid", int'(rd_valid), 0);
        rst_n = 1'b1;

        // Fill, overflow, simultaneous op while full, drain, underflow.
        for (int i = 0; i < 20; i++) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].data);
            chk("vec_count", int'(count), vecs[i].cnt);
            chk("vec_flags", int'({full, empty, almost_full, almost_empty, overflow, underflow}),
                int'({vecs[i].f, vecs[i].e, vecs[i].af, vecs[i].ae, vecs[i].ov, vecs[i].un}));
        end

        // Simultaneous read/write at count 4 keeps occupancy.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'(16'h0100 + i));
        step(1'b1, 1'b1, 16'h0104);
        chk("rw_at_4_count", int'(count), 4);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0);

        // 20-word stream; pointers wrap more than twice.
        step(1'b1, 1'b0, 16'h2000);
        for (int i = 1; i < 20; i++) step(1'b1, 1'b1, DW'(16'h2000 + i));
        step(1'b0, 1'b1, '0);
        chk("stream_drained", int'(count), 0);

        // Randomised traffic against the scoreboard.
        for (int i = 0; i < 300; i++)
            step(1'(($urandom % 3) != 0), 1'(($urandom % 3) != 0), DW'($urandom));
        while (sb_q.size() != 0) step(1'b0, 1'b1, '0);

        // Asynchronous reset with count 5 and rd_valid high.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, DW'(16'h3000 + i));
        step(1'b0, 1'b1, '0);
        chk("pre_rst_count", int'(count), 5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_empty", int'(empty), 1);
        chk("async_rst_rd_valid", int'(rd_valid), 0);
        sb_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, 1'b0, 16'h1234);
        step(1'b0, 1'b1, '0);
`ifndef SYNC_FIFO_FWFT_EN
        chk("post_rst_word", int'(rd_data), 16'h1234);
`endif
        chk("post_rst_count", int'(count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
